// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared geometry and character-cell layout for the VGA text buffer
package vga_text_pkg;
  localparam int VGA_COLS   = 80;
  localparam int VGA_ROWS   = 60;
  localparam int ROW_STRIDE = 40;
  localparam int ADDR_W     = 12;
  localparam int EVEN_BG_LSB = 28;
  localparam int EVEN_FG_LSB = 24;
  localparam int EVEN_CH_LSB = 16;
  localparam int ODD_BG_LSB  = 12;
  localparam int ODD_FG_LSB  = 8;
  localparam int ODD_CH_LSB  = 0;
  localparam int COLOUR_W    = 4;
  localparam int CHAR_W      = 8;
endpackage

// File: rtl/row_addr_mult.sv
// row_addr_mult: constant multiply of a character row by the per-row word stride
module row_addr_mult #(
  parameter int ADDR_W = vga_text_pkg::ADDR_W,
  parameter int STRIDE = vga_text_pkg::ROW_STRIDE
) (
  input  logic [5:0]        row_i,
  output logic [ADDR_W-1:0] product_o
);
  assign product_o = ADDR_W'(row_i) * ADDR_W'(STRIDE);
endmodule

// File: rtl/vga_text_blk_mem.sv
// vga_text_blk_mem: byte-writable text buffer with row/column read addressing
// and a read-first, one-cycle-latency display port
module vga_text_blk_mem #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_W     = vga_text_pkg::ADDR_W,
  parameter int DATA_W     = 32,
  parameter int ROW_STRIDE = vga_text_pkg::ROW_STRIDE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [5:0]          i_row,
  input  logic [6:0]          i_col,
  output logic [ADDR_W-1:0]   o_raddr,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [ADDR_W-1:0] row_base;
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;
  row_addr_mult #(.ADDR_W(ADDR_W), .STRIDE(ROW_STRIDE)) u_mult (
    .row_i     (i_row),
    .product_o (row_base)
  );
  assign o_raddr = row_base + ADDR_W'(i_col >> 1);
  assign o_rdata = rdata_q;
  // Nonblocking read of the array gives read-first behaviour on address collisions.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else begin
      for (int k = 0; k < DATA_W/8; k++)
        if (i_we[k]) mem_q[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      rdata_q <= mem_q[o_raddr];
    end
  end
endmodule

// File: tb/tb_vga_text_blk_mem.sv
// tb_vga_text_blk_mem: directed self-checking bench for the VGA text buffer
module tb_vga_text_blk_mem;
  logic        i_clk = 0;
  logic        i_rst_n = 0;
  logic [3:0]  i_we = '0;
  logic [11:0] i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic [5:0]  i_row = '0;
  logic [6:0]  i_col = '0;
  logic [11:0] o_raddr;
  logic [31:0] o_rdata;
  int vectors = 0;
  int errors = 0;

  vga_text_blk_mem dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_row(i_row), .i_col(i_col),
    .o_raddr(o_raddr), .o_rdata(o_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic wr(input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_we = we; i_waddr = a; i_wdata = d;
    @(negedge i_clk);
    i_we = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    repeat (2) @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp %h", o_rdata, 32'h0);
    end
    i_rst_n = 1;
  endtask

  task automatic test_full_word();
    wr(4'hF, 12'd41, 32'h1F41_2E42);
    i_row = 6'd1; i_col = 7'd2;
    #1;
    vectors++;
    if (o_raddr !== 12'd41) begin
      errors++; $display("FAIL full_word_raddr got %0d exp %0d", o_raddr, 41);
    end
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'h1F41_2E42) begin
      errors++; $display("FAIL full_word_rdata got %h exp %h", o_rdata, 32'h1F41_2E42);
    end
  endtask

  task automatic test_byte_lanes();
    wr(4'hF, 12'd0, 32'hAABB_CCDD);
    wr(4'b0101, 12'd0, 32'h1122_3344);
    i_row = 6'd0; i_col = 7'd0;
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'hAA22_CC44) begin
      errors++; $display("FAIL byte_lanes got %h exp %h", o_rdata, 32'hAA22_CC44);
    end
    wr(4'h0, 12'd0, 32'hFFFF_FFFF);
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'hAA22_CC44) begin
      errors++; $display("FAIL byte_we_zero got %h exp %h", o_rdata, 32'hAA22_CC44);
    end
  endtask

  task automatic test_addr_gen();
    logic [11:0] exp_a [3] = '{12'd2399, 12'd0, 12'd2583};
    logic [5:0]  rows  [3] = '{6'd59, 6'd0, 6'd63};
    logic [6:0]  cols  [3] = '{7'd79, 7'd1, 7'd127};
    for (int i = 0; i < 3; i++) begin
      i_row = rows[i]; i_col = cols[i];
      #1;
      vectors++;
      if (o_raddr !== exp_a[i]) begin
        errors++; $display("FAIL addr_corner%0d got %0d exp %0d", i, o_raddr, exp_a[i]);
      end
    end
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) begin
        i_row = 6'(r); i_col = 7'(c);
        #1;
        vectors++;
        if (o_raddr !== 12'(r * 40 + c / 2)) begin
          errors++;
          $display("FAIL addr_sweep r%0d c%0d got %0d exp %0d", r, c, o_raddr, r * 40 + c / 2);
        end
      end
  endtask

  task automatic test_read_during_write();
    @(negedge i_clk);
    i_row = 6'd0; i_col = 7'd10;
    i_we = 4'hF; i_waddr = 12'd5; i_wdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_we = '0;
    vectors++;
    if (o_rdata !== 32'h0) begin
      errors++; $display("FAIL rdw_old got %h exp %h", o_rdata, 32'h0);
    end
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdw_new got %h exp %h", o_rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_reset_write();
    wr(4'hF, 12'd7, 32'h1234_5678);
    i_row = 6'd0; i_col = 7'd14;
    @(negedge i_clk);
    i_rst_n = 0;
    i_we = 4'hF; i_waddr = 12'd7; i_wdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_write_rdata got %h exp %h", o_rdata, 32'h0);
    end
    i_we = '0;
    i_rst_n = 1;
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rst_preserve got %h exp %h", o_rdata, 32'h1234_5678);
    end
    i_col = 7'd10;
    @(negedge i_clk);
    vectors++;
    if (o_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rst_preserve_old got %h exp %h", o_rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 40; w++) wr(4'hF, 12'(80 + w), 32'hC0DE_0000 + 32'(w * 3 + 1));
    @(negedge i_clk);
    i_row = 6'd2; i_col = 7'd0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge i_clk);
      vectors++;
      if (o_rdata !== 32'hC0DE_0000 + 32'(((c - 1) / 2) * 3 + 1)) begin
        errors++;
        $display("FAIL latency col%0d got %h exp %h", c - 1, o_rdata,
                 32'hC0DE_0000 + 32'(((c - 1) / 2) * 3 + 1));
      end
      if (c < 80) i_col = 7'(c);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_addr_gen();
    test_read_during_write();
    test_reset_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
